bcd_ascii_field_serializer: RTL



---
 rtl/bcd_ascii_field_serializer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bcd_ascii_field_serializer.sv
// bcd_ascii_field_serializer
// Turns one packed BCD word into an AXI-Stream run of ASCII decimal bytes,
// optionally dropping leading zeros and appending a field delimiter (FIX SOH).
// One field per input transaction, one byte per cycle when not back-pressured.

module bcd_ascii_field_serializer #(
  parameter int unsigned NUM_DIGITS  = 6,
  parameter bit          SUPPRESS_LZ = 1'b1,
  parameter bit          APPEND_TERM = 1'b1,
  parameter logic [7:0]  TERM_BYTE   = 8'h01
) (
  input  logic                    axis_aclk,
  input  logic                    axis_resetn,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [7:0]              out_tdata,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic                    out_tlast,
  output logic                    bcd_err
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    TERM = 2'd2
  } state_e;

  state_e                  state_q,      state_d;
  logic [IDX_W-1:0]        idx_q,        idx_d;
  logic [4*NUM_DIGITS-1:0] data_q,       data_d;
  logic                    in_ready_q,   in_ready_d;
  logic                    out_tvalid_q, out_tvalid_d;
  logic [7:0]              out_tdata_q,  out_tdata_d;
  logic                    out_tlast_q,  out_tlast_d;
  logic                    bcd_err_q,    bcd_err_d;

  logic [3:0]       in_digits   [NUM_DIGITS];
  logic [3:0]       held_digits [NUM_DIGITS];
  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] next_idx;
  logic             in_bad;
  logic             handshake;

  // ASCII code of one digit; anything outside 0..9 shows up as '?'.
  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : {4'h3, d};
  endfunction

  assign handshake = out_tvalid_q && out_tready;
  assign next_idx  = idx_q - IDX_W'(1);

  // Split the incoming and the held words into per-digit views.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      in_digits[i]   = bcd_in[4*i +: 4];
      held_digits[i] = data_q[4*i +: 4];
    end
  end

  // Find the first digit to emit and flag any non-decimal digit in the new word.
  always_comb begin
    start_idx = '0;
    in_bad    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (in_digits[i] > 4'd9) begin
        in_bad = 1'b1;
      end
      // Ascending scan: the last hit is the most significant nonzero digit,
      // and an all-zero word leaves start_idx at 0 so one '0' is still sent.
      if (!SUPPRESS_LZ || (in_digits[i] != 4'd0)) begin
        start_idx = IDX_W'(i);
      end
    end
  end

  // Next-state and next-output logic for the IDLE -> EMIT -> TERM sequence.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    data_d       = data_q;
    in_ready_d   = in_ready_q;
    out_tvalid_d = out_tvalid_q;
    out_tdata_d  = out_tdata_q;
    out_tlast_d  = out_tlast_q;
    bcd_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d       = bcd_in;
          idx_d        = start_idx;
          state_d      = EMIT;
          in_ready_d   = 1'b0;
          out_tvalid_d = 1'b1;
          out_tdata_d  = to_ascii(in_digits[start_idx]);
          out_tlast_d  = !APPEND_TERM && (start_idx == '0);
          bcd_err_d    = in_bad;
        end
      end

      EMIT: begin
        if (handshake) begin
          if (idx_q == '0) begin
            if (APPEND_TERM) begin
              state_d     = TERM;
              out_tdata_d = TERM_BYTE;
              out_tlast_d = 1'b1;
            end else begin
              state_d      = IDLE;
              out_tvalid_d = 1'b0;
              out_tlast_d  = 1'b0;
              in_ready_d   = 1'b1;
            end
          end else begin
            idx_d       = next_idx;
            out_tdata_d = to_ascii(held_digits[next_idx]);
            out_tlast_d = !APPEND_TERM && (next_idx == '0);
          end
        end
      end

      TERM: begin
        if (handshake) begin
          state_d      = IDLE;
          out_tvalid_d = 1'b0;
          out_tlast_d  = 1'b0;
          in_ready_d   = 1'b1;
        end
      end

      default: begin
        state_d      = IDLE;
        out_tvalid_d = 1'b0;
        out_tlast_d  = 1'b0;
        in_ready_d   = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset aborts any field in flight.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      data_q       <= '0;
      in_ready_q   <= 1'b1;
      out_tvalid_q <= 1'b0;
      out_tdata_q  <= 8'h00;
      out_tlast_q  <= 1'b0;
      bcd_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values of the others, independent of statement order.
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      in_ready_q   <= in_ready_d;
      out_tvalid_q <= out_tvalid_d;
      out_tdata_q  <= out_tdata_d;
      out_tlast_q  <= out_tlast_d;
      bcd_err_q    <= bcd_err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_tvalid = out_tvalid_q;
  assign out_tdata  = out_tdata_q;
  assign out_tlast  = out_tlast_q;
  assign bcd_err    = bcd_err_q;

endmodule
